power_ctrl: RTL



---
 rtl/power_pkg.sv | 8 +
 rtl/power_ctrl_if.sv | 26 ++
 rtl/pow_exp_shifter.sv | 19 +
 rtl/power_ctrl.sv | 111 +++++++++++
 4 files changed

// File: rtl/power_pkg.sv
// power_pkg: state encoding and IEEE-754 field constants shared by the power sequencer.
package power_pkg;
    typedef enum logic [2:0] {IDLE, EVAL, MUL_ACC, WAIT_ACC, MUL_SQ, WAIT_SQ, FINISH} state_t;
    localparam logic [31:0] ONE_FP   = 32'h3F800000;
    localparam int          SIGN_BIT = 31;
    localparam int          EXP_MSB  = 30;
    localparam int          EXP_LSB  = 23;
endpackage

// File: rtl/power_ctrl_if.sv
// power_ctrl_if: request/response signals from the decoder plus the shared multiplier handshake.
interface power_ctrl_if #(parameter int EXP_W = 8);
    logic             start;
    logic [31:0]      base;
    logic [EXP_W-1:0] exp_n;
    logic             busy;
    logic             done;
    logic [31:0]      result;
    logic             overflow;
    logic             underflow;
    logic             mul_start;
    logic [31:0]      mul_a;
    logic [31:0]      mul_b;
    logic             mul_done;
    logic [31:0]      mul_result;
    logic             mul_ovf;
    logic             mul_unf;
    modport slave (
        input  start, base, exp_n, mul_done, mul_result, mul_ovf, mul_unf,
        output busy, done, result, overflow, underflow, mul_start, mul_a, mul_b
    );
    modport master (
        output start, base, exp_n, mul_done, mul_result, mul_ovf, mul_unf,
        input  busy, done, result, overflow, underflow, mul_start, mul_a, mul_b
    );
endinterface

// File: rtl/pow_exp_shifter.sv
// pow_exp_shifter: exponent register consumed LSB-first, with zero and last-bit detection.
module pow_exp_shifter #(parameter int EXP_W = 8) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [EXP_W-1:0] n_i,
    output logic             lsb_o,
    output logic             zero_o,
    output logic             last_o
);
    logic [EXP_W-1:0] n_q, n_d;
    always_comb n_d = load_i ? n_i : shift_i ? n_q >> 1 : n_q;
    always_ff @(posedge CLK) n_q <= !RST ? '0 : n_d;
    assign lsb_o  = n_q[0];
    assign zero_o = n_q == '0;
    // last_o: nothing remains once the current bit is consumed
    assign last_o = (n_q >> 1) == '0;
endmodule

// File: rtl/power_ctrl.sv
// power_ctrl: right-to-left square-and-multiply sequencer computing base^n on a shared FP multiplier.
// Optional macro POWER_SHORTCUT_EN resolves zero/denormal, one and n==1 cases without multiplying.
module power_ctrl #(
    parameter int          EXP_W  = 8,
    parameter logic [31:0] ONE_FP = power_pkg::ONE_FP
) (
    input logic         CLK,
    input logic         RST,
    power_ctrl_if.slave bus
);
    import power_pkg::*;
    state_t      state_q, state_d;
    logic [31:0] acc_q, acc_d, sq_q, sq_d, result_q, result_d, mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic        ovf_q, ovf_d, unf_q, unf_d;
    logic        load, shift, n_lsb, n_zero, n_last;
    pow_exp_shifter #(.EXP_W(EXP_W)) u_shift (
        .CLK(CLK), .RST(RST), .load_i(load), .shift_i(shift), .n_i(bus.exp_n),
        .lsb_o(n_lsb), .zero_o(n_zero), .last_o(n_last)
    );
`ifdef POWER_SHORTCUT_EN
    logic first_q;
    always_ff @(posedge CLK) first_q <= RST && state_q == IDLE;
`endif
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        sq_d    = sq_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        load    = 1'b0;
        shift   = 1'b0;
        case (state_q)
            IDLE: if (bus.start) begin
                acc_d   = ONE_FP;
                sq_d    = bus.base;
                ovf_d   = 1'b0;
                unf_d   = 1'b0;
                load    = 1'b1;
                state_d = EVAL;
            end
            EVAL: begin
                if (n_zero) state_d = FINISH;
`ifdef POWER_SHORTCUT_EN
                else if (first_q && (sq_q[EXP_MSB:EXP_LSB] == '0 || sq_q == ONE_FP || (n_lsb && n_last))) begin
                    acc_d   = sq_q[EXP_MSB:EXP_LSB] == '0 ? {sq_q[SIGN_BIT] & n_lsb, 31'b0} : sq_q;
                    state_d = FINISH;
                end
`endif
                else if (n_lsb) state_d = MUL_ACC;
                else begin
                    shift   = 1'b1;
                    state_d = n_last ? FINISH : MUL_SQ;
                end
            end
            MUL_ACC: state_d = WAIT_ACC;
            WAIT_ACC: if (bus.mul_done) begin
                acc_d   = bus.mul_result;
                shift   = 1'b1;
                ovf_d   = ovf_q | bus.mul_ovf;
                unf_d   = unf_q | bus.mul_unf;
                state_d = (bus.mul_ovf || bus.mul_unf || n_last) ? FINISH : MUL_SQ;
            end
            MUL_SQ: state_d = WAIT_SQ;
            // a flagged square is reported through acc so FINISH has a single source
            WAIT_SQ: if (bus.mul_done) begin
                sq_d    = bus.mul_result;
                ovf_d   = ovf_q | bus.mul_ovf;
                unf_d   = unf_q | bus.mul_unf;
                acc_d   = (bus.mul_ovf || bus.mul_unf) ? bus.mul_result : acc_q;
                state_d = (bus.mul_ovf || bus.mul_unf) ? FINISH : EVAL;
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    // operands are latched one cycle ahead so they are valid with mul_start and hold through the wait
    always_comb begin
        result_d = state_d == FINISH ? acc_d : result_q;
        mul_a_d  = state_d == MUL_ACC ? acc_q : state_d == MUL_SQ ? sq_q : mul_a_q;
        mul_b_d  = (state_d == MUL_ACC || state_d == MUL_SQ) ? sq_q : mul_b_q;
    end
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            sq_q     <= '0;
            result_q <= '0;
            mul_a_q  <= '0;
            mul_b_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            sq_q     <= sq_d;
            result_q <= result_d;
            mul_a_q  <= mul_a_d;
            mul_b_q  <= mul_b_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end
    assign bus.busy      = state_q != IDLE && state_q != FINISH;
    assign bus.done      = state_q == FINISH;
    assign bus.mul_start = state_q == MUL_ACC || state_q == MUL_SQ;
    assign bus.mul_a     = mul_a_q;
    assign bus.mul_b     = mul_b_q;
    assign bus.result    = result_q;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
endmodule
